ae_sensor_reg_writer: RTL and testbench

//  Downstream of the AE histogram stage: takes each post_valid pulse with exposure_time/exposure_gain,

---
 rtl/ae_sensor_reg_writer.sv | 185 ++++++++++++++++++
 tb/tb_ae_sensor_reg_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ae_sensor_reg_writer.sv
// rtl/ae_sensor_reg_writer.sv - turns AE exposure/gain updates into grouped-hold sensor register write bursts
// Latest-wins pending slot feeds a six-write burst; identical settings are skipped, NACKs get one retry.
module ae_sensor_reg_writer #(
   parameter logic [7:0]  DEV_ADDR = 8'h6C,
   parameter logic [15:0] EXP_REG  = 16'h3501,
   parameter logic [15:0] GAIN_REG = 16'h350A,
   parameter logic [15:0] HOLD_REG = 16'h3208,
   parameter logic [15:0] EXP_MAX  = 16'd10000,
   parameter logic [15:0] GAIN_MAX = 16'd256,
   parameter logic [23:0] TIMEOUT  = 24'd1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        ae_valid,
   input  logic [15:0] exposure_time,
   input  logic [15:0] exposure_gain,
   output logic        wr_req,
   output logic [7:0]  wr_dev,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   input  logic        wr_ack,
   input  logic        wr_err,
   output logic        busy,
   output logic [15:0] update_cnt,
   output logic        err_flag
);

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

   state_t      state_q;
   logic        pend_q;
   logic [15:0] pend_exp_q, pend_gain_q;
   logic [15:0] work_exp_q, work_gain_q;
   logic [15:0] last_exp_q, last_gain_q;
   logic [2:0]  idx_q;
   logic        retry_q;
   logic [23:0] tmo_q;
   logic        wr_req_q;
   logic [15:0] wr_addr_q;
   logic [7:0]  wr_data_q;
   logic        busy_q;
   logic [15:0] update_cnt_q;
   logic        err_flag_q;

   logic        capture;
   logic [23:0] tmo_d;
   logic [2:0]  idx_d;
   logic        changed;

   function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] vmax);
      if (v == 16'd0) return 16'd1;
      if (v > vmax) return vmax;
      return v;
   endfunction

   // Burst order: open group hold, exposure hi/lo, gain hi/lo, close hold and launch.
   function automatic logic [15:0] tbl_addr(input logic [2:0] idx);
      case (idx)
         3'd1:    return EXP_REG;
         3'd2:    return EXP_REG + 16'd1;
         3'd3:    return GAIN_REG;
         3'd4:    return GAIN_REG + 16'd1;
         default: return HOLD_REG;
      endcase
   endfunction

   function automatic logic [7:0] tbl_data(input logic [2:0] idx, input logic [15:0] e,
                                           input logic [15:0] g);
      case (idx)
         3'd0:    return 8'h00;
         3'd1:    return e[15:8];
         3'd2:    return e[7:0];
         3'd3:    return g[15:8];
         3'd4:    return g[7:0];
         default: return 8'hA0;
      endcase
   endfunction

   assign capture = ae_valid & init_done;
   assign tmo_d   = tmo_q + 24'd1;
   assign idx_d   = idx_q + 3'd1;
   assign changed = (pend_exp_q != last_exp_q) || (pend_gain_q != last_gain_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         pend_q       <= 1'b0;
         pend_exp_q   <= 16'd0;
         pend_gain_q  <= 16'd0;
         work_exp_q   <= 16'd0;
         work_gain_q  <= 16'd0;
         last_exp_q   <= 16'd0;
         last_gain_q  <= 16'd0;
         idx_q        <= 3'd0;
         retry_q      <= 1'b0;
         tmo_q        <= 24'd0;
         wr_req_q     <= 1'b0;
         wr_addr_q    <= 16'd0;
         wr_data_q    <= 8'd0;
         busy_q       <= 1'b0;
         update_cnt_q <= 16'd0;
         err_flag_q   <= 1'b0;
      end else begin
         if (capture) begin
            pend_q      <= 1'b1;
            pend_exp_q  <= clamp(exposure_time, EXP_MAX);
            pend_gain_q <= clamp(exposure_gain, GAIN_MAX);
         end
         case (state_q)
            IDLE: begin
               if (pend_q) begin
                  if (!capture) pend_q <= 1'b0;
                  work_exp_q  <= pend_exp_q;
                  work_gain_q <= pend_gain_q;
                  if (changed) begin
                     busy_q    <= 1'b1;
                     idx_q     <= 3'd0;
                     retry_q   <= 1'b0;
                     tmo_q     <= 24'd0;
                     wr_req_q  <= 1'b1;
                     wr_addr_q <= tbl_addr(3'd0);
                     wr_data_q <= tbl_data(3'd0, pend_exp_q, pend_gain_q);
                     state_q   <= REQ;
                  end
               end
            end
            REQ: begin
               // Error wins over a simultaneous ack.
               if (wr_err) begin
                  wr_req_q <= 1'b0;
                  if (retry_q) begin
                     err_flag_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     retry_q <= 1'b1;
                     state_q <= GAP;
                  end
               end else if (wr_ack) begin
                  wr_req_q <= 1'b0;
                  retry_q  <= 1'b0;
                  if (idx_q == 3'd5) begin
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_d;
                     state_q <= GAP;
                  end
               end else if (tmo_d >= TIMEOUT) begin
                  wr_req_q   <= 1'b0;
                  err_flag_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            GAP: begin
               wr_req_q  <= 1'b1;
               tmo_q     <= 24'd0;
               wr_addr_q <= tbl_addr(idx_q);
               wr_data_q <= tbl_data(idx_q, work_exp_q, work_gain_q);
               state_q   <= REQ;
            end
            DONE: begin
               last_exp_q   <= work_exp_q;
               last_gain_q  <= work_gain_q;
               update_cnt_q <= update_cnt_q + 16'd1;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_req     = wr_req_q;
   assign wr_dev     = DEV_ADDR;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign update_cnt = update_cnt_q;
   assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_ae_sensor_reg_writer.sv
// tb/tb_ae_sensor_reg_writer.sv - self-checking bench for ae_sensor_reg_writer
`timescale 1ns/1ps
module tb_ae_sensor_reg_writer;
   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst, init_done, ae_valid, wr_ack, wr_err;
   logic [15:0] exposure_time, exposure_gain;
   logic        wr_req, busy, err_flag;
   logic [7:0]  wr_dev, wr_data;
   logic [15:0] wr_addr, update_cnt;

   int checks = 0, failures = 0;
   int m_last_e = 0, m_last_g = 0, m_cnt = 0;
   logic [15:0] got_a[$];
   logic [7:0]  got_d[$];

   typedef struct {
      int e_in;
      int g_in;
      bit burst;
      int we;
      int wg;
   } vec_t;
   vec_t tbl[8];

   ae_sensor_reg_writer #(.TIMEOUT(24'(TMO))) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .ae_valid(ae_valid),
      .exposure_time(exposure_time), .exposure_gain(exposure_gain),
      .wr_req(wr_req), .wr_dev(wr_dev), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy), .update_cnt(update_cnt),
      .err_flag(err_flag)
   );

   always #5 clk = ~clk;

   function automatic int clampv(input int v, input int vmax);
      if (v < 1) return 1;
      if (v > vmax) return vmax;
      return v;
   endfunction

   function automatic logic [23:0] model_write(input int i, input int e, input int g);
      case (i)
         0:       return {16'h3208, 8'h00};
         1:       return {16'h3501, 8'(e / 256)};
         2:       return {16'h3502, 8'(e % 256)};
         3:       return {16'h350A, 8'(g / 256)};
         4:       return {16'h350B, 8'(g % 256)};
         default: return {16'h3208, 8'hA0};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ae(input int e, input int g);
      ae_valid      = 1'b1;
      exposure_time = 16'(e);
      exposure_gain = 16'(g);
      step();
      ae_valid = 1'b0;
   endtask

   // Acts as the I2C controller: records each request, responds after delay cycles.
   task automatic serve(input int delay, input int err_idx, input int n_err, output bit aborted);
      int w, errs, t;
      logic [15:0] a;
      w = 0; errs = 0; aborted = 1'b0;
      got_a.delete(); got_d.delete();
      while (w < 6) begin
         t = 0;
         while (!wr_req && t < 100) begin step(); t++; end
         if (!wr_req) begin
            check("req_wait", 32'(t), 32'd0);
            aborted = 1'b1;
            return;
         end
         if (got_a.size() > 0) check("gap", 32'(t), 32'd1);
         a = wr_addr;
         got_a.push_back(wr_addr);
         got_d.push_back(wr_data);
         for (int k = 0; k < delay; k++) step();
         check("hold", 32'({wr_req, wr_addr}), 32'({1'b1, a}));
         if (w == err_idx && errs < n_err) begin
            wr_err = 1'b1; step(); wr_err = 1'b0;
            errs++;
            if (errs == 2) begin aborted = 1'b1; return; end
         end else begin
            wr_ack = 1'b1; step(); wr_ack = 1'b0;
            w++;
         end
      end
   endtask

   task automatic check_writes(input int e, input int g);
      check("n_writes", 32'(got_a.size()), 32'd6);
      for (int i = 0; i < got_a.size() && i < 6; i++)
         check("write", 32'({got_a[i], got_d[i]}), 32'(model_write(i, e, g)));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 20) begin step(); t++; end
      check("busy_low", 32'(busy), 32'd0);
   endtask

   task automatic finish_burst(input int e, input int g);
      check_writes(e, g);
      wait_idle();
      m_last_e = e; m_last_g = g; m_cnt = (m_cnt + 1) % 65536;
      check("update_cnt", 32'(update_cnt), 32'(m_cnt));
   endtask

   task automatic expect_none();
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (wr_req || busy) seen++;
      end
      check("no_burst", 32'(seen), 32'd0);
      check("cnt_same", 32'(update_cnt), 32'(m_cnt));
   endtask

   task automatic apply(input int e, input int g, input bit want, input int we, input int wg,
                        input int delay);
      bit ab;
      pulse_ae(e, g);
      if (want) begin
         check("lat_n1", 32'(wr_req), 32'd0);
         step();
         check("lat_n2", 32'(wr_req), 32'd1);
         serve(delay, -1, 0, ab);
         finish_burst(we, wg);
      end else begin
         expect_none();
      end
   endtask

   initial begin
      bit ab;
      int n, e, g, ce, cg, r;
      tbl[0] = '{32'h0134, 32'h0010, 1'b1, 32'h0134, 32'h0010};
      tbl[1] = '{32'h0134, 32'h0010, 1'b0, 0, 0};
      tbl[2] = '{32'h0134, 32'h0018, 1'b1, 32'h0134, 32'h0018};
      tbl[3] = '{32'hFFFF, 32'h0000, 1'b1, 32'h2710, 32'h0001};
      tbl[4] = '{32'h2710, 32'h0001, 1'b0, 0, 0};
      tbl[5] = '{32'h0001, 32'h0100, 1'b1, 32'h0001, 32'h0100};
      tbl[6] = '{32'h0000, 32'h0101, 1'b0, 0, 0};
      tbl[7] = '{32'h2711, 32'h00FF, 1'b1, 32'h2710, 32'h00FF};

      rst = 1'b0; init_done = 1'b0; ae_valid = 1'b0; wr_ack = 1'b0; wr_err = 1'b0;
      exposure_time = 16'd0; exposure_gain = 16'd0;
      repeat (3) step();
      check("rst_outputs", 32'({wr_req, busy, err_flag, update_cnt, wr_data}), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      check("wr_dev", 32'(wr_dev), 32'h6C);
      rst = 1'b1;
      step();

      pulse_ae(32'h0134, 32'h0010);
      expect_none();
      init_done = 1'b1;

      for (int i = 0; i < 8; i++)
         apply(tbl[i].e_in, tbl[i].g_in, tbl[i].burst, tbl[i].we, tbl[i].wg, 3);

      // single NACK on idx 2 is retried
      pulse_ae(32'h0234, 32'h0020);
      step();
      serve(1, 2, 1, ab);
      check("retry_ok", 32'(ab), 32'd0);
      check("retry_n", 32'(got_a.size()), 32'd7);
      if (got_a.size() == 7) begin
         check("retry_a2", 32'({got_a[2], got_d[2]}), 32'h350234);
         check("retry_a3", 32'({got_a[3], got_d[3]}), 32'h350234);
         got_a.delete(3); got_d.delete(3);
      end
      finish_burst(32'h0234, 32'h0020);
      check("err_flag0", 32'(err_flag), 32'd0);

      // double NACK aborts, identical request then re-bursts
      pulse_ae(32'h0300, 32'h0030);
      step();
      serve(1, 2, 2, ab);
      check("abort", 32'(ab), 32'd1);
      check("abort_state", 32'({wr_req, busy, err_flag}), 32'b001);
      check("abort_cnt", 32'(update_cnt), 32'(m_cnt));
      apply(32'h0300, 32'h0030, 1'b1, 32'h0300, 32'h0030, 0);

      // three updates during a burst -> one follow-up with the last values
      pulse_ae(32'h0111, 32'h0011);
      step();
      check("bd_req", 32'(wr_req), 32'd1);
      pulse_ae(32'h0222, 32'h0022);
      pulse_ae(32'h0333, 32'h0033);
      pulse_ae(32'h0444, 32'h0044);
      serve(2, -1, 0, ab);
      finish_burst(32'h0111, 32'h0011);
      serve(1, -1, 0, ab);
      finish_burst(32'h0444, 32'h0044);
      expect_none();

      for (int it = 0; it < 20; it++) begin
         r = $urandom_range(0, 4);
         e = (r == 0) ? m_last_e : (r == 1) ? 0 : (r == 2) ? $urandom_range(10000, 65535)
                                                          : $urandom_range(1, 9999);
         r = $urandom_range(0, 4);
         g = (r == 0) ? m_last_g : (r == 1) ? 0 : (r == 2) ? $urandom_range(256, 65535)
                                                          : $urandom_range(1, 255);
         ce = clampv(e, 10000);
         cg = clampv(g, 256);
         apply(e, g, (ce != m_last_e) || (cg != m_last_g), ce, cg, $urandom_range(0, 3));
      end

      // asynchronous reset in the middle of a request
      pulse_ae(32'h0555, 32'h0055);
      step();
      check("pre_rst_req", 32'(wr_req), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("async_rst", 32'({wr_req, busy, err_flag, update_cnt, wr_data}), 32'd0);
      check("async_rst_addr", 32'(wr_addr), 32'd0);
      step();
      rst = 1'b1;
      m_last_e = 0; m_last_g = 0; m_cnt = 0;
      step();

      // no response at all -> timeout abort
      pulse_ae(32'h0666, 32'h0066);
      step();
      n = 0;
      while (wr_req && n < 200) begin n++; step(); end
      check("tmo_cycles", 32'(n), 32'(TMO));
      check("tmo_state", 32'({wr_req, busy, err_flag}), 32'b001);
      check("tmo_cnt", 32'(update_cnt), 32'd0);
      apply(32'h0666, 32'h0066, 1'b1, 32'h0666, 32'h0066, 1);
      check("err_sticky", 32'(err_flag), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
